cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: NUM_FU, 5, number of functional-unit completion ports; index i matches free[i] bit at the reservation station.
REQ-002 Parameter: TAG_W, 6, width of REG.num (physical tag number).
REQ-003 Port: clock  input  1  single clock; all state updates on posedge.
REQ-004 Port: reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-005 Port: squash  input  1  synchronous flush of all buffered, not-yet-broadcast results.
REQ-006 Port: fu_done  input  NUM_FU  per-FU completion strobe, one result per asserted cycle.
REQ-007 Port: fu_tag  input  NUM_FU x REG  destination tag per FU; only .num is used.
REQ-008 Port: fu_stall  output  NUM_FU  per-FU back-pressure; FU i holds fu_done/fu_tag while fu_stall[i]=1.
REQ-009 Port: cdb_ready  output  1  registered; CDB carries a valid tag this cycle.
REQ-010 Port: cdb_tag  output  REG  registered; broadcast tag, .ready=1 whenever cdb_ready=1, else all-zero.
REQ-011 Port: free  output  NUM_FU  registered-state-derived; free[i]=1 when FU i holding buffer is empty.

Function
REQ-012 Each FU SHALL own one holding buffer: valid bit + TAG_W tag.
REQ-013 Buffer i SHALL accept when fu_done[i]=1 and (buffer empty or buffer granted this cycle); accepted tag and valid=1 load at posedge.
REQ-014 fu_stall[i] SHALL be combinational: valid[i] & ~grant[i]; no result is ever dropped or duplicated.
REQ-015 Exactly one valid buffer SHALL be granted per cycle by round-robin: search starts at rr_ptr, wraps NUM_FU-1 -> 0.
REQ-016 On a grant to index g, rr_ptr SHALL load (g+1) mod NUM_FU; with no grant rr_ptr SHALL hold.
REQ-017 Granted buffer SHALL clear at posedge unless REQ-013 reloads it same edge (back-to-back completion keeps valid=1).
REQ-018 On grant with tag.num != 0, cdb_ready<=1 and cdb_tag<={num, ready=1} at the same posedge.
REQ-019 On grant with tag.num == 0 (no destination, e.g. store), buffer SHALL clear but cdb_ready<=0, cdb_tag<=0; it still consumes the grant slot.
REQ-020 With no grant, cdb_ready<=0 and cdb_tag<=0 (one-cycle broadcast pulses only).
REQ-021 Latency: fu_done at cycle N with no contention -> cdb_ready=1 in cycle N+2 (capture edge, then broadcast edge).
REQ-022 free[i] SHALL be ~valid[i]; it deasserts the cycle after capture and reasserts the cycle after the grant edge.
REQ-023 squash=1 SHALL at posedge clear all valid bits, cdb_ready, cdb_tag, and ignore same-cycle fu_done; rr_ptr SHALL reset to 0; fu_stall SHALL read 0 during the squash cycle.
REQ-024 squash SHALL take priority over fu_done and grant in the same cycle.
REQ-025 All NUM_FU buffers valid: each SHALL be broadcast within NUM_FU cycles (starvation-free).

Reset
REQ-026 On reset: all valid=0, rr_ptr=0, cdb_ready=0, cdb_tag=0, free=all ones, fu_stall=0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered results without broadcast; first broadcast after release requires a new fu_done.

Verification
REQ-028 Single: reset, then fu_done=5'b00100, fu_tag[2].num=5 at cycle 1 -> free[2]=0 cycle 2, cdb_ready=1 cdb_tag.num=5 cycle 3, free=5'b11111 cycle 3.
REQ-029 Contention: fu_done=5'b10011 tags 7,8,9 (FU0,1,4) same cycle, rr_ptr=0 -> broadcasts 7,8,9 in consecutive cycles; fu_stall[4]=1 for two cycles, fu_stall[1]=1 for one.
REQ-030 Zero tag: fu_done[3]=1 with tag.num=0 -> free[3] pulses low one cycle, cdb_ready stays 0 throughout.
REQ-031 Back-to-back: FU0 done every cycle, tags 1,2,3, no other FUs -> cdb_tag.num 1,2,3 on consecutive cycles, fu_stall[0]=0 throughout.
REQ-032 Fairness: all five FUs held done continuously -> grant order 0,1,2,3,4,0,... ; no FU waits more than 5 cycles.
REQ-033 Squash/reset: three buffers valid, assert squash (then separately async reset mid-cycle) -> no cdb_ready afterwards, free=5'b11111 next cycle (immediately for reset).

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding buffer per functional unit, round-robin
// grant of one buffered result per cycle onto a registered broadcast bus.
package cdb_arbiter_pkg;
    localparam int unsigned TAG_W = 6;

    typedef struct packed {
        logic [TAG_W-1:0] num;
        logic             ready;
    } reg_t;
endpackage

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU = 5,
    parameter int unsigned TAG_W  = cdb_arbiter_pkg::TAG_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              squash,
    input  logic [NUM_FU-1:0] fu_done,
    input  reg_t [NUM_FU-1:0] fu_tag,
    output logic [NUM_FU-1:0] fu_stall,
    output logic              cdb_ready,
    output reg_t              cdb_tag,
    output logic [NUM_FU-1:0] free
);

    localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q [NUM_FU];
    logic [TAG_W-1:0]  tag_d [NUM_FU];
    logic [PTR_W-1:0]  rr_q, rr_d;
    logic              cdb_ready_q, cdb_ready_d;
    reg_t              cdb_tag_q, cdb_tag_d;

    logic [NUM_FU-1:0] grant;
    logic              grant_vld;
    logic [PTR_W-1:0]  grant_idx;
    int unsigned       scan;

    // Round-robin search starting at rr_q, wrapping at NUM_FU-1.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan      = 0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            scan = 32'(rr_q) + k;
            if (scan >= NUM_FU) begin
                scan = scan - NUM_FU;
            end
            if (!grant_vld && valid_q[PTR_W'(scan)]) begin
                grant_vld = 1'b1;
                grant_idx = PTR_W'(scan);
            end
        end
        grant = grant_vld ? (NUM_FU'(1) << grant_idx) : '0;
    end

    // A granted buffer is free to take a new result on the same edge.
    always_comb begin
        valid_d     = valid_q;
        tag_d       = tag_q;
        rr_d        = rr_q;
        cdb_ready_d = 1'b0;
        cdb_tag_d   = '0;
        if (squash) begin
            valid_d = '0;
            rr_d    = '0;
        end else begin
            if (grant_vld) begin
                valid_d[grant_idx] = 1'b0;
                rr_d = (32'(grant_idx) == NUM_FU - 1) ? '0 : grant_idx + 1'b1;
                // Tag 0 means no destination: slot is consumed but nothing is broadcast.
                if (tag_q[grant_idx] != '0) begin
                    cdb_ready_d     = 1'b1;
                    cdb_tag_d.num   = tag_q[grant_idx];
                    cdb_tag_d.ready = 1'b1;
                end
            end
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (fu_done[i] && (!valid_q[i] || grant[i])) begin
                    valid_d[i] = 1'b1;
                    tag_d[i]   = fu_tag[i].num;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q     <= '0;
            rr_q        <= '0;
            cdb_ready_q <= 1'b0;
            cdb_tag_q   <= '0;
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            rr_q        <= rr_d;
            cdb_ready_q <= cdb_ready_d;
            cdb_tag_q   <= cdb_tag_d;
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign fu_stall  = squash ? '0 : (valid_q & ~grant);
    assign free      = ~valid_q;
    assign cdb_ready = cdb_ready_q;
    assign cdb_tag   = cdb_tag_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic, all checked
// against a queue-per-FU reference model with round-robin pick by modulo search.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned N = 5;

    logic         clock = 1'b0;
    logic         reset;
    logic         squash;
    logic [N-1:0] fu_done;
    reg_t [N-1:0] fu_tag;
    logic [N-1:0] fu_stall;
    logic         cdb_ready;
    reg_t         cdb_tag;
    logic [N-1:0] free;

    always #5 clock = ~clock;

    cdb_arbiter #(.NUM_FU(N), .TAG_W(TAG_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .squash   (squash),
        .fu_done  (fu_done),
        .fu_tag   (fu_tag),
        .fu_stall (fu_stall),
        .cdb_ready(cdb_ready),
        .cdb_tag  (cdb_tag),
        .free     (free)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: each FU owns a queue holding at most one pending tag.
    int unsigned m_q [N][$];
    int unsigned m_rr;
    bit          m_rdy;
    int unsigned m_cdb;

    logic [N-1:0] drv_done;
    logic [5:0]   drv_tag [N];
    logic         drv_sq;
    logic [N-1:0] last_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_pick();
        for (int unsigned k = 0; k < N; k++) begin
            if (m_q[(m_rr + k) % N].size() != 0) return int'((m_rr + k) % N);
        end
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_q[i].delete();
        m_rr  = 0;
        m_rdy = 1'b0;
        m_cdb = 0;
    endtask

    // Called at a negedge: check registered outputs, drive, check stall, advance one cycle.
    task automatic step();
        int           g;
        logic [N-1:0] exp_free;
        logic [N-1:0] exp_stall;
        for (int i = 0; i < N; i++) exp_free[i] = (m_q[i].size() == 0);
        check("cdb_ready", 32'(cdb_ready), 32'(m_rdy));
        check("cdb_num", 32'(cdb_tag.num), m_rdy ? m_cdb : 32'd0);
        check("cdb_rdybit", 32'(cdb_tag.ready), 32'(m_rdy));
        check("free", 32'(free), 32'(exp_free));
        fu_done = drv_done;
        squash  = drv_sq;
        for (int i = 0; i < N; i++) begin
            fu_tag[i].num   = drv_tag[i];
            fu_tag[i].ready = 1'b0;
        end
        #1;
        g = m_pick();
        for (int i = 0; i < N; i++) exp_stall[i] = !drv_sq && (m_q[i].size() != 0) && (g != i);
        check("fu_stall", 32'(fu_stall), 32'(exp_stall));
        if (drv_sq) begin
            m_reset();
        end else begin
            m_rdy = 1'b0;
            m_cdb = 0;
            if (g >= 0) begin
                int unsigned t;
                t    = m_q[g].pop_front();
                m_rr = (32'(g) + 1) % N;
                if (t != 0) begin
                    m_rdy = 1'b1;
                    m_cdb = t;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (drv_done[i] && m_q[i].size() == 0) m_q[i].push_back(32'(drv_tag[i]));
            end
        end
        last_stall = exp_stall;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drv_idle();
        drv_done = '0;
        drv_sq   = 1'b0;
        for (int i = 0; i < N; i++) drv_tag[i] = '0;
    endtask

    // Async reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_free", 32'(free), 32'h1f);
        check("rst_cdb_ready", 32'(cdb_ready), 32'd0);
        check("rst_cdb_tag", 32'(cdb_tag), 32'd0);
        check("rst_stall", 32'(fu_stall), 32'd0);
        m_reset();
        drv_idle();
        last_stall = '0;
        fu_done = '0;
        squash  = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        squash     = 1'b0;
        fu_done    = '0;
        fu_tag     = '0;
        last_stall = '0;
        drv_idle();
        m_reset();
        #1;
        check("init_free", 32'(free), 32'h1f);
        check("init_cdb_ready", 32'(cdb_ready), 32'd0);
        check("init_stall", 32'(fu_stall), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Single result, no contention: broadcast two edges after fu_done.
        drv_done = 5'b00100;
        drv_tag[2] = 6'd5;
        step();
        check("single_free_lo", 32'(free), 32'h1b);
        drv_idle();
        step();
        check("single_ready", 32'(cdb_ready), 32'd1);
        check("single_num", 32'(cdb_tag.num), 32'd5);
        check("single_free_hi", 32'(free), 32'h1f);
        step();

        // Zero tag: buffer occupied one cycle, never broadcast.
        drv_done = 5'b01000;
        drv_tag[3] = 6'd0;
        step();
        check("zero_free_lo", 32'(free), 32'h17);
        check("zero_ready_a", 32'(cdb_ready), 32'd0);
        drv_idle();
        step();
        check("zero_free_hi", 32'(free), 32'h1f);
        check("zero_ready_b", 32'(cdb_ready), 32'd0);
        step();

        // Back-to-back completions on FU0 stream without stalling.
        for (int k = 0; k < 5; k++) begin
            drv_done   = (k < 3) ? 5'b00001 : 5'b00000;
            drv_tag[0] = 6'(k + 1);
            step();
            check("b2b_stall", 32'(fu_stall), 32'd0);
            if (k >= 1 && k <= 3) check("b2b_num", 32'(cdb_tag.num), 32'(k));
        end
        drv_idle();
        step();

        // Contention from rr_ptr=0: FU0, FU1, FU4 in order.
        do_reset();
        drv_done = 5'b10011;
        drv_tag[0] = 6'd7;
        drv_tag[1] = 6'd8;
        drv_tag[4] = 6'd9;
        step();
        check("cont_stall_a", 32'(fu_stall), 32'h12);
        drv_idle();
        step();
        check("cont_stall_b", 32'(fu_stall), 32'h10);
        check("cont_num_a", 32'(cdb_tag.num), 32'd7);
        step();
        check("cont_stall_c", 32'(fu_stall), 32'd0);
        check("cont_num_b", 32'(cdb_tag.num), 32'd8);
        step();
        check("cont_num_c", 32'(cdb_tag.num), 32'd9);
        step();
        check("cont_idle", 32'(cdb_ready), 32'd0);

        // Fairness: all FUs held done; grant order cycles 0..4.
        do_reset();
        drv_done = 5'b11111;
        for (int i = 0; i < N; i++) drv_tag[i] = 6'(10 + i);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k >= 2) check("fair_num", 32'(cdb_tag.num), 32'(10 + (k - 2) % N));
        end
        drv_idle();
        repeat (6) step();

        // Squash flushes buffered results and ignores same-cycle completions.
        do_reset();
        drv_done = 5'b00111;
        drv_tag[0] = 6'd1;
        drv_tag[1] = 6'd2;
        drv_tag[2] = 6'd3;
        step();
        check("sq_free_pre", 32'(free), 32'h18);
        drv_sq   = 1'b1;
        drv_done = 5'b11000;
        drv_tag[3] = 6'd4;
        drv_tag[4] = 6'd6;
        step();
        check("sq_free_post", 32'(free), 32'h1f);
        drv_idle();
        for (int k = 0; k < 3; k++) begin
            step();
            check("sq_no_bcast", 32'(cdb_ready), 32'd0);
        end

        // Random traffic with FU hold-while-stalled protocol, squash and a mid-run reset.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc == 700) begin
                do_reset();
            end
            for (int i = 0; i < N; i++) begin
                if (!(last_stall[i] && drv_done[i])) begin
                    drv_done[i] = ($urandom_range(0, 99) < 45);
                    drv_tag[i]  = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
                end
            end
            drv_sq = ($urandom_range(0, 49) == 0);
            step();
        end
        drv_idle();
        repeat (8) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
